// File: rtl/adc_serial_capture_if.sv
// adc_serial_capture_if: control and serial-bus signals between the ADC capture block and its environment
// Signals:
//   enable       - controller -> capture, allows new frames to start
//   sclk_in      - divided serial clock, sampled as data by the capture block
//   miso         - ADC serial data
//   cs_n         - ADC chip select, active-low
//   sample       - last completed sample (DATA_BITS wide)
//   sample_valid - one-cycle strobe when sample updates
//   busy         - high while cs_n is low
// Modports: master drives enable/sclk_in/miso, slave is the capture block.
interface adc_serial_capture_if #(
    parameter int DATA_BITS = 12
);
    logic                 enable;
    logic                 sclk_in;
    logic                 miso;
    logic                 cs_n;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 busy;
    modport master (output enable, sclk_in, miso, input cs_n, sample, sample_valid, busy);
    modport slave  (input enable, sclk_in, miso, output cs_n, sample, sample_valid, busy);
endinterface

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: ADCS7476-style serial frame capture driven by an oversampled divided sclk
// Ports:
//   inClock - system clock; all logic runs here, sclk_in is only sampled
//   reset   - synchronous, active-high
//   bus     - adc_serial_capture_if.slave (enable, sclk_in, miso in; cs_n, sample, sample_valid, busy out)
// Optional build macro ADC_SIGNED_OUT_EN: sample becomes two's complement centred on midscale.
module adc_serial_capture #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int QUIET_EDGES = 2
) (
    input logic                 inClock,
    input logic                 reset,
    adc_serial_capture_if.slave bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_EDGES + 1);

    if (DATA_BITS > FRAME_BITS || QUIET_EDGES < 1) begin : g_bad_params
        $error("adc_serial_capture: need DATA_BITS <= FRAME_BITS and QUIET_EDGES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

    state_t               r_state, w_next;
    logic                 r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                 r_miso_s1, r_miso_s2;
    logic [CW-1:0]        r_bit_cnt;
    logic [QW-1:0]        r_quiet_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_sample;
    logic [DATA_BITS-1:0] w_sample;
    logic                 r_cs_n;
    logic                 r_valid;
    logic                 w_rise, w_fall;

    assign w_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_fall = ~r_sclk_s2 & r_sclk_s3;

    // Only the trailing DATA_BITS of the frame are kept: the leading zeros
    // simply shift out of the top of a DATA_BITS-wide register.
`ifdef ADC_SIGNED_OUT_EN
    assign w_sample = r_shift ^ (DATA_BITS'(1) << (DATA_BITS - 1));
`else
    assign w_sample = r_shift;
`endif

    always_ff @(posedge inClock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Starting on a detected fall guarantees the next rise is frame bit 0.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  w_next = (bus.enable && w_fall) ? SHIFT : IDLE;
            SHIFT: w_next = (w_rise && r_bit_cnt == CW'(FRAME_BITS - 1)) ? DONE : SHIFT;
            DONE:  w_next = QUIET;
            QUIET: w_next = (w_rise && r_quiet_cnt == QW'(QUIET_EDGES - 1)) ? IDLE : QUIET;
        endcase
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_s3   <= 1'b0;
            r_miso_s1   <= 1'b0;
            r_miso_s2   <= 1'b0;
            r_bit_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_shift     <= '0;
            r_sample    <= '0;
            r_cs_n      <= 1'b1;
            r_valid     <= 1'b0;
        end else begin
            r_sclk_s1 <= bus.sclk_in;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_miso_s1 <= bus.miso;
            r_miso_s2 <= r_miso_s1;
            // cs_n is registered from the next state so it is glitch-free at the pin
            r_cs_n    <= (w_next != SHIFT);
            // sample and its strobe update together at the end of the DONE cycle
            r_valid   <= (r_state == DONE);
            if (r_state == SHIFT && w_rise) begin
                r_shift   <= DATA_BITS'({r_shift, r_miso_s2});
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if (r_state == DONE) begin
                r_sample  <= w_sample;
                r_bit_cnt <= '0;
            end
            if (r_state == QUIET && w_rise)
                r_quiet_cnt <= (w_next == IDLE) ? '0 : r_quiet_cnt + QW'(1);
        end
    end

    assign bus.cs_n         = r_cs_n;
    assign bus.busy         = ~r_cs_n;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed + randomized frames against an ADC behavioural model
module tb_adc_serial_capture;
    logic inClock = 1'b0;
    logic reset;
    adc_serial_capture_if #(.DATA_BITS(12)) bus ();

    adc_serial_capture #(.FRAME_BITS(16), .DATA_BITS(12), .QUIET_EDGES(2)) dut (
        .inClock(inClock),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 inClock = ~inClock;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int sclk_half = 1, phase = 0;
    bit sclk_run = 0;
    logic [15:0] adc_word = 16'h0;
    int idx = 0;
    logic prev_cs = 1'b1;
    int cs_falls = 0, valid_count = 0, raw_rises = 0, high_rises = 0;
    int fall_cyc = 0, raw_rise_cyc = 0, prev_valid_cyc = 0, last_valid_cyc = 0;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] model(input logic [15:0] w);
`ifdef ADC_SIGNED_OUT_EN
        return w[11:0] - 12'd2048;
`else
        return w[11:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge inClock);
        #1;
    endtask

    task automatic wait_gt(input int sel, input int base, input string tag);
        int t = 0;
        while ((sel == 0 ? cs_falls : sel == 1 ? valid_count : raw_rises) <= base && t < 3000) begin
            step();
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 3000), 1);
    endtask

    task automatic frame(input logic [11:0] code, input bit last);
        int c0 = cs_falls;
        int v0 = valid_count;
        adc_word   = {4'h0, code};
        bus.enable = 1'b1;
        wait_gt(0, c0, "frame_cs");
        if (last) bus.enable = 1'b0;
        wait_gt(1, v0, "frame_valid");
    endtask

    initial forever begin
        @(posedge inClock);
        cyc++;
    end

    // Serial clock generator, ADC model and output monitor.
    initial forever begin
        @(negedge inClock);
        if (bus.sample_valid === 1'b1) begin
            valid_count++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            chk("valid_latency", 32'(cyc - raw_rise_cyc), 4);
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(valid_count), 0);
            else chk("sample_value", 32'(bus.sample), 32'(exp_q.pop_front()));
        end
        if (prev_cs === 1'b1 && bus.cs_n === 1'b0) begin
            cs_falls++;
            chk("cs_fall_latency", 32'(cyc - fall_cyc), 3);
            idx      = 15;
            bus.miso = adc_word[15];
            exp_q.push_back(model(adc_word));
        end
        prev_cs = bus.cs_n;
        if (sclk_run) begin
            phase++;
            if (phase >= sclk_half) begin
                phase = 0;
                bus.sclk_in = ~bus.sclk_in;
                if (bus.sclk_in) begin
                    raw_rises++;
                    raw_rise_cyc = cyc;
                    if (bus.cs_n === 1'b1) high_rises++;
                end else begin
                    fall_cyc = cyc;
                    if (bus.cs_n === 1'b0 && idx > 0) begin
                        idx--;
                        bus.miso = adc_word[idx];
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, v0, r0;
        logic [11:0] codes[7];
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.sclk_in = 1'b0;
        bus.miso    = 1'b0;
        sclk_run    = 1;
        repeat (3) step();
        chk("rst_cs_n", 32'(bus.cs_n), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sample", 32'(bus.sample), 0);
        chk("rst_no_valid", valid_count, 0);
        reset     = 1'b0;
        sclk_half = 10;
        phase     = 0;
        repeat (60) step();
        chk("idle_no_cs", cs_falls, 0);
        chk("idle_no_valid", valid_count, 0);

        v0 = valid_count;
        frame(12'hAC3, 1);
        chk("single_sample", 32'(bus.sample), 32'(model(16'h0AC3)));
        repeat (60) step();
        chk("single_one_pulse", valid_count, v0 + 1);
        chk("single_hold", 32'(bus.sample), 32'(model(16'h0AC3)));
        chk("single_cs_idle", 32'(bus.cs_n), 1);

        frame(12'hFFF, 0);
        high_rises = 0;
        frame(12'h001, 1);
        chk("b2b_quiet_rises", high_rises, 2);
        chk("b2b_gap", 32'((last_valid_cyc - prev_valid_cyc) >= 18 * 20), 1);
        chk("b2b_sample", 32'(bus.sample), 32'(model(16'h0001)));

        codes[0] = 12'h800;
        codes[1] = 12'h000;
        codes[2] = 12'hFFF;
        for (int i = 3; i < 7; i++) codes[i] = 12'($urandom);
        c0 = cs_falls;
        for (int i = 0; i < 7; i++) frame(codes[i], i == 6);
        repeat (60) step();
        chk("seq_frames", cs_falls, c0 + 7);
        chk("seq_last_sample", 32'(bus.sample), 32'(model({4'h0, codes[6]})));

        c0 = cs_falls;
        v0 = valid_count;
        adc_word   = {4'h0, 12'($urandom)};
        bus.enable = 1'b1;
        wait_gt(0, c0, "en_cs");
        r0 = raw_rises;
        wait_gt(2, r0 + 7, "en_rises");
        bus.enable = 1'b0;
        wait_gt(1, v0, "en_valid");
        repeat (120) step();
        chk("en_no_restart", cs_falls, c0 + 1);
        chk("en_valid_once", valid_count, v0 + 1);

        c0 = cs_falls;
        v0 = valid_count;
        adc_word   = {4'h0, 12'($urandom)};
        bus.enable = 1'b1;
        wait_gt(0, c0, "rstmid_cs");
        r0 = raw_rises;
        wait_gt(2, r0 + 9, "rstmid_rises");
        reset = 1'b1;
        step();
        chk("rstmid_cs_n", 32'(bus.cs_n), 1);
        chk("rstmid_sample", 32'(bus.sample), 0);
        exp_q.delete();
        bus.enable = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (40) step();
        chk("rstmid_no_valid", valid_count, v0);
        frame(12'h555, 1);
        chk("rstmid_555", 32'(bus.sample), 32'(model(16'h0555)));
        repeat (60) step();
        chk("final_cs_idle", 32'(bus.cs_n), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
